wb_unit: RTL and testbench

WB_UNIT -- requirements
Module: wb_unit

---
 rtl/wb_unit.sv | 161 ++++++++++++++++
 tb/tb_wb_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/wb_unit.sv
// Write-back stage: selects ALU result or formatted load data, waits for late load data, times out stalled loads.
// Optional FP write port enabled by defining WB_FP_WRITEBACK_EN.
module wb_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] W_alu_out,
  input  logic [4:0]  W_rd,
  input  logic [4:0]  W_rd_f,
  input  logic [2:0]  W_funct3,
  input  logic        W_reg_write_enable,
  input  logic        W_reg_write_enable_f,
  input  logic        W_wb_data_sel,
  input  logic [31:0] dm_rdata,
  input  logic        dm_rvalid,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        frf_we,
  output logic [4:0]  frf_waddr,
  output logic        wb_stall,
  output logic        wb_timeout_err
);

  // dm_rvalid qualifies dm_rdata for exactly one cycle; there is no ready side:
  // the word is consumed whenever a load is presented (IDLE) or pending (WAIT_LOAD), otherwise dropped.
  typedef enum logic {IDLE = 1'b0, WAIT_LOAD = 1'b1} state_t;

  state_t      state, state_next;
  logic [5:0]  wait_cnt;
  logic [4:0]  p_rd, p_rd_f;
  logic [2:0]  p_funct3;
  logic [1:0]  p_off;
  logic        p_we, p_wef;
  logic        in_we_f, load_req, capture, timeout;
  logic        wr_we, wr_wef;
  logic [4:0]  wr_rd, wr_rd_f;
  logic [31:0] wr_data;
  logic        frf_we_q;
  logic [4:0]  frf_waddr_q;

`ifdef WB_FP_WRITEBACK_EN
  assign in_we_f   = W_reg_write_enable_f;
  assign frf_we    = frf_we_q;
  assign frf_waddr = frf_waddr_q;
`else
  logic unused_fp;
  assign in_we_f   = 1'b0;
  assign frf_we    = 1'b0;
  assign frf_waddr = 5'd0;
  assign unused_fp = ^{frf_we_q, frf_waddr_q, W_reg_write_enable_f};
`endif

  function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    // Halfword ignores off[0]: misaligned halfwords silently use the aligned half.
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  format_load = {{24{b[7]}}, b};
      3'b100:  format_load = {24'd0, b};
      3'b001:  format_load = {{16{h[15]}}, h};
      3'b101:  format_load = {16'd0, h};
      default: format_load = d;
    endcase
  endfunction

  assign load_req = W_wb_data_sel && (W_reg_write_enable || in_we_f);
  assign wb_stall = (state == WAIT_LOAD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    wr_we      = 1'b0;
    wr_wef     = 1'b0;
    wr_rd      = W_rd;
    wr_rd_f    = W_rd_f;
    wr_data    = W_alu_out;
    capture    = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (!W_wb_data_sel) begin
          wr_we  = W_reg_write_enable;
          wr_wef = in_we_f;
        end else if (load_req) begin
          if (dm_rvalid) begin
            wr_we   = W_reg_write_enable;
            wr_wef  = in_we_f;
            wr_data = format_load(W_funct3, W_alu_out[1:0], dm_rdata);
          end else begin
            capture    = 1'b1;
            state_next = WAIT_LOAD;
          end
        end
      end
      WAIT_LOAD: begin
        wr_rd   = p_rd;
        wr_rd_f = p_rd_f;
        wr_data = format_load(p_funct3, p_off, dm_rdata);
        if (dm_rvalid) begin
          wr_we      = p_we;
          wr_wef     = p_wef;
          state_next = IDLE;
        end else if (wait_cnt == 6'd63) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt       <= 6'd0;
      p_rd           <= 5'd0;
      p_rd_f         <= 5'd0;
      p_funct3       <= 3'd0;
      p_off          <= 2'd0;
      p_we           <= 1'b0;
      p_wef          <= 1'b0;
      rf_we          <= 1'b0;
      rf_waddr       <= 5'd0;
      rf_wdata       <= 32'd0;
      frf_we_q       <= 1'b0;
      frf_waddr_q    <= 5'd0;
      wb_timeout_err <= 1'b0;
    end else begin
      if (capture) begin
        wait_cnt <= 6'd0;
        p_rd     <= W_rd;
        p_rd_f   <= W_rd_f;
        p_funct3 <= W_funct3;
        p_off    <= W_alu_out[1:0];
        p_we     <= W_reg_write_enable;
        p_wef    <= in_we_f;
      end else if (state == WAIT_LOAD && !dm_rvalid && wait_cnt != 6'd63) begin
        wait_cnt <= wait_cnt + 6'd1;
      end
      if (timeout) wb_timeout_err <= 1'b1;
      // x0 is hardwired zero on the integer file only.
      rf_we       <= wr_we && (wr_rd != 5'd0);
      rf_waddr    <= wr_rd;
      rf_wdata    <= wr_data;
      frf_we_q    <= wr_wef;
      frf_waddr_q <= wr_rd_f;
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed cases plus random ALU/load traffic against a reference model.
module tb_wb_unit;

`ifdef WB_FP_WRITEBACK_EN
  localparam bit FP_EN = 1'b1;
`else
  localparam bit FP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] W_alu_out;
  logic [4:0]  W_rd, W_rd_f;
  logic [2:0]  W_funct3;
  logic        W_reg_write_enable, W_reg_write_enable_f, W_wb_data_sel;
  logic [31:0] dm_rdata;
  logic        dm_rvalid;
  logic        rf_we, frf_we, wb_stall, wb_timeout_err;
  logic [4:0]  rf_waddr, frf_waddr;
  logic [31:0] rf_wdata;

  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  logic        err_exp = 1'b0;
  // {cycle[15:0], rf_we, rf_waddr, frf_we, frf_waddr, rf_wdata}
  logic [59:0] exp_q[$];

  wb_unit dut (
    .clk(clk), .rst(rst),
    .W_alu_out(W_alu_out), .W_rd(W_rd), .W_rd_f(W_rd_f), .W_funct3(W_funct3),
    .W_reg_write_enable(W_reg_write_enable), .W_reg_write_enable_f(W_reg_write_enable_f),
    .W_wb_data_sel(W_wb_data_sel), .dm_rdata(dm_rdata), .dm_rvalid(dm_rvalid),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .frf_we(frf_we), .frf_waddr(frf_waddr),
    .wb_stall(wb_stall), .wb_timeout_err(wb_timeout_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_format(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * off)) & 32'hFF;
    h = (d >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_nop();
    W_alu_out = 32'd0; W_rd = 5'd0; W_rd_f = 5'd0; W_funct3 = 3'd0;
    W_reg_write_enable = 1'b0; W_reg_write_enable_f = 1'b0; W_wb_data_sel = 1'b0;
    dm_rdata = 32'd0; dm_rvalid = 1'b0;
  endtask

  task automatic drive_random_w();
    W_alu_out = $urandom; W_rd = 5'($urandom); W_rd_f = 5'($urandom);
    W_funct3 = 3'($urandom); W_reg_write_enable = 1'($urandom);
    W_reg_write_enable_f = 1'($urandom); W_wb_data_sel = 1'($urandom);
  endtask

  // Presents one instruction at a negedge; lat = cycles until the load word arrives
  // (0 = same cycle, >64 = never). Returns at the negedge where its write is visible.
  task automatic issue(input logic [31:0] alu, input logic [4:0] rd, input logic [4:0] rd_f,
                       input logic [2:0] f3, input logic we, input logic wef, input logic sel,
                       input logic [31:0] rdata, input int lat);
    logic        eff_wef, load, exp_rf, pulse, timed_out;
    logic [31:0] exp_data;
    int          waits, stalls;
    eff_wef   = FP_EN & wef;
    load      = sel & (we | eff_wef);
    timed_out = load && (lat > 64);
    waits     = (load && lat > 0) ? ((lat > 64) ? 64 : lat) : 0;
    exp_rf    = we && (rd != 5'd0);
    exp_data  = sel ? ref_format(f3, alu[1:0], rdata) : alu;
    pulse     = (exp_rf || eff_wef) && !timed_out;
    if (pulse)
      exp_q.push_back({16'(cyc + waits + 1), exp_rf, exp_rf ? rd : 5'd0,
                       eff_wef, eff_wef ? rd_f : 5'd0, exp_data});
    W_alu_out = alu; W_rd = rd; W_rd_f = rd_f; W_funct3 = f3;
    W_reg_write_enable = we; W_reg_write_enable_f = wef; W_wb_data_sel = sel;
    dm_rvalid = load ? (lat == 0) : 1'($urandom_range(0, 1));
    dm_rdata  = (load && lat == 0) ? rdata : $urandom;
    @(negedge clk);
    stalls = 0;
    for (int k = 1; k <= waits; k++) begin
      stalls += int'(wb_stall);
      drive_random_w();
      dm_rvalid = (k == lat);
      dm_rdata  = (k == lat) ? rdata : $urandom;
      @(negedge clk);
    end
    if (waits > 0) check("stall_cycles", 64'(stalls), 64'(waits));
    check("stall_clear", {63'd0, wb_stall}, 64'd0);
    if (!pulse) check("no_write", {62'd0, rf_we, frf_we}, 64'd0);
    if (timed_out) err_exp = 1'b1;
    check("timeout_err", {63'd0, wb_timeout_err}, {63'd0, err_exp});
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [59:0] act;
    if (rst && (rf_we || frf_we)) begin
      act = {16'(cyc), rf_we, rf_we ? rf_waddr : 5'd0, frf_we, frf_we ? frf_waddr : 5'd0, rf_wdata};
      if (exp_q.size() == 0) check("unexpected_write", 64'(act), 64'd0);
      else check("wb_write", 64'(act), 64'(exp_q.pop_front()));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] rrd;
    int         kind, lat;
    rst = 1'b0;
    drive_random_w();
    dm_rvalid = 1'b1; dm_rdata = $urandom;
    #3;
    check("reset_outputs", 64'({rf_we, rf_waddr, rf_wdata, frf_we, frf_waddr, wb_stall, wb_timeout_err}), 64'd0);
    @(negedge clk);
    drive_nop();
    rst = 1'b1;

    issue(32'h1234_5678, 5'd5, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0, 32'd0, 0);        // ALU
    issue(32'h0, 5'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 0);                 // pulse drops
    issue(32'h0000_0002, 5'd9, 5'd0, 3'b000, 1'b1, 1'b0, 1'b1, 32'h0080_0000, 0); // LB
    issue(32'h0000_0002, 5'd9, 5'd0, 3'b100, 1'b1, 1'b0, 1'b1, 32'h0080_0000, 0); // LBU
    issue(32'h0000_0002, 5'd7, 5'd0, 3'b001, 1'b1, 1'b0, 1'b1, 32'h8001_0000, 3); // LH late
    issue(32'h0000_0003, 5'd8, 5'd0, 3'b101, 1'b1, 1'b0, 1'b1, 32'hFEDC_BA98, 0); // LHU off[0]=1
    issue(32'hDEAD_BEEF, 5'd0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0, 32'd0, 0);         // x0
    issue(32'h0000_0000, 5'd0, 5'd3, 3'b010, 1'b0, 1'b1, 1'b1, 32'h3F80_0000, 0); // FP LW
    issue(32'h0000_0004, 5'd4, 5'd6, 3'b010, 1'b1, 1'b1, 1'b1, 32'hCAFE_F00D, 2); // dual write
    issue(32'h0000_0001, 5'd10, 5'd0, 3'b000, 1'b1, 1'b0, 1'b1, 32'h0000_7F00, 63);
    issue(32'h0000_0000, 5'd11, 5'd0, 3'b010, 1'b1, 1'b0, 1'b1, 32'h5555_AAAA, 64); // last cycle
    issue(32'h0000_0000, 5'd12, 5'd0, 3'b010, 1'b1, 1'b0, 1'b1, 32'h1111_1111, 100); // timeout
    issue(32'h0BAD_F00D, 5'd13, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0, 32'd0, 0);        // sticky err

    // Asynchronous reset while a load is pending.
    W_alu_out = 32'd0; W_rd = 5'd12; W_funct3 = 3'b010; W_reg_write_enable = 1'b1;
    W_reg_write_enable_f = 1'b0; W_wb_data_sel = 1'b1; dm_rvalid = 1'b0;
    @(negedge clk);
    drive_nop();
    repeat (2) @(negedge clk);
    check("stall_before_reset", {63'd0, wb_stall}, 64'd1);
    #2 rst = 1'b0;
    #1 check("reset_async", 64'({rf_we, rf_waddr, rf_wdata, frf_we, frf_waddr, wb_stall, wb_timeout_err}), 64'd0);
    err_exp = 1'b0;
    dm_rvalid = 1'b1; dm_rdata = $urandom;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_quiet", {61'd0, rf_we, frf_we, wb_stall}, 64'd0);
    end
    dm_rvalid = 1'b0;

    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 9);
      rrd  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      if (kind < 4) lat = 0;
      else if (kind < 7) lat = 0;
      else if (kind < 9) lat = $urandom_range(1, 8);
      else lat = ($urandom_range(0, 19) == 0) ? $urandom_range(60, 70) : $urandom_range(9, 40);
      issue($urandom, rrd, 5'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
            kind >= 4, $urandom, lat);
    end

    drive_nop();
    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
